// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable terminal value, synchronous load,
// wrap/saturate boundary mode, terminal-count pulse and sticky overflow flag.
module counter_updown_mod #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] limit,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam bit SAT_MODE = (SATURATE != 0);

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             boundary;

   // Next-state: boundary detection happens before any +/-1 so nothing overflows WIDTH.
   always_comb begin
      q_d      = q_q;
      tc_d     = 1'b0;
      ovf_d    = ovf_q;
      boundary = 1'b0;

      if (load) begin
         q_d = (d > limit) ? limit : d;
      end else if (en) begin
         if (up) begin
            if (q_q >= limit) begin
               boundary = 1'b1;
               q_d      = SAT_MODE ? limit : '0;
            end else begin
               q_d = q_q + WIDTH'(1);
            end
         end else begin
            if (q_q == '0) begin
               boundary = 1'b1;
               q_d      = SAT_MODE ? '0 : limit;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end
      end

      tc_d = boundary;
      // A boundary event in the same cycle as a clear keeps the flag set.
      if (boundary) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = q_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: a wrap instance and a saturate instance share stimulus.
module tb_counter_updown_mod;

   logic       clk;
   logic       rst, en, up, load, clr_ovf;
   logic [3:0] d, limit;
   logic [3:0] q_w, q_s;
   logic       tc_w, tc_s, ovf_w, ovf_s;

   int checks = 0;
   int errors = 0;

   counter_updown_mod #(.WIDTH(4), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .limit(limit), .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .ovf(ovf_w));

   counter_updown_mod #(.WIDTH(4), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .limit(limit), .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .ovf(ovf_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; clr_ovf = 1'b0; d = '0;
   endtask

   task automatic test_reset();
      idle();
      limit = 4'd9;
      rst   = 1'b1;
      step();
      checks++;
      if ({q_w, tc_w, ovf_w} !== 6'b0000_0_0) begin
         errors++;
         $display("FAIL reset_wrap: q/tc/ovf=%0d/%0b/%0b expected 0/0/0", q_w, tc_w, ovf_w);
      end
      checks++;
      if ({q_s, tc_s, ovf_s} !== 6'b0000_0_0) begin
         errors++;
         $display("FAIL reset_sat: q/tc/ovf=%0d/%0b/%0b expected 0/0/0", q_s, tc_s, ovf_s);
      end
   endtask

   task automatic test_count_up();
      logic [5:0] ew, es;
      idle();
      limit = 4'd9; en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         ew = {4'(i % 10), 1'(i == 10), 1'(i >= 10)};
         es = {4'((i <= 9) ? i : 9), 1'(i >= 10), 1'(i >= 10)};
         checks++;
         if ({q_w, tc_w, ovf_w} !== ew) begin
            errors++;
            $display("FAIL count_up_wrap step %0d: q/tc/ovf=%0d/%0b/%0b expected %0d/%0b/%0b",
                     i, q_w, tc_w, ovf_w, ew[5:2], ew[1], ew[0]);
         end
         checks++;
         if ({q_s, tc_s, ovf_s} !== es) begin
            errors++;
            $display("FAIL count_up_sat step %0d: q/tc/ovf=%0d/%0b/%0b expected %0d/%0b/%0b",
                     i, q_s, tc_s, ovf_s, es[5:2], es[1], es[0]);
         end
      end
   endtask

   task automatic test_count_down_clr();
      int wq[5] = '{2, 1, 0, 9, 8};
      int wt[5] = '{0, 0, 0, 1, 0};
      int sq[5] = '{2, 1, 0, 0, 0};
      int st[5] = '{0, 0, 0, 1, 1};
      idle();
      limit = 4'd9; load = 1'b1; d = 4'd3;
      step();
      checks++;
      if ({q_w, tc_w, q_s, tc_s} !== {4'd3, 1'b0, 4'd3, 1'b0}) begin
         errors++;
         $display("FAIL load3: wrap q/tc=%0d/%0b sat q/tc=%0d/%0b expected 3/0 both",
                  q_w, tc_w, q_s, tc_s);
      end
      load = 1'b0; en = 1'b1; up = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({q_w, tc_w, ovf_w} !== {4'(wq[i]), 1'(wt[i]), 1'b1}) begin
            errors++;
            $display("FAIL down_wrap step %0d: q/tc/ovf=%0d/%0b/%0b expected %0d/%0d/1",
                     i, q_w, tc_w, ovf_w, wq[i], wt[i]);
         end
         checks++;
         if ({q_s, tc_s, ovf_s} !== {4'(sq[i]), 1'(st[i]), 1'b1}) begin
            errors++;
            $display("FAIL down_sat step %0d: q/tc/ovf=%0d/%0b/%0b expected %0d/%0d/1",
                     i, q_s, tc_s, ovf_s, sq[i], st[i]);
         end
      end
      en = 1'b0; clr_ovf = 1'b1;
      step();
      checks++;
      if ({q_w, tc_w, ovf_w, q_s, tc_s, ovf_s} !== {4'd8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL clr_ovf: wrap %0d/%0b/%0b sat %0d/%0b/%0b expected 8/0/0 and 0/0/0",
                  q_w, tc_w, ovf_w, q_s, tc_s, ovf_s);
      end
   endtask

   task automatic test_saturate();
      int sq[4] = '{15, 15, 15, 15};
      int wq[4] = '{15, 0, 1, 2};
      int st[4] = '{0, 1, 1, 1};
      int wt[4] = '{0, 1, 0, 0};
      idle();
      limit = 4'd15; load = 1'b1; d = 4'd14;
      step();
      checks++;
      if ({q_w, q_s, ovf_w, ovf_s} !== {4'd14, 4'd14, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load14: wrap q=%0d sat q=%0d ovf=%0b/%0b expected 14 14 0/0",
                  q_w, q_s, ovf_w, ovf_s);
      end
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({q_s, tc_s, ovf_s} !== {4'(sq[i]), 1'(st[i]), 1'(i >= 1)}) begin
            errors++;
            $display("FAIL sat_up step %0d: q/tc/ovf=%0d/%0b/%0b expected %0d/%0d/%0b",
                     i, q_s, tc_s, ovf_s, sq[i], st[i], i >= 1);
         end
         checks++;
         if ({q_w, tc_w, ovf_w} !== {4'(wq[i]), 1'(wt[i]), 1'(i >= 1)}) begin
            errors++;
            $display("FAIL wrap_up15 step %0d: q/tc/ovf=%0d/%0b/%0b expected %0d/%0d/%0b",
                     i, q_w, tc_w, ovf_w, wq[i], wt[i], i >= 1);
         end
      end
      load = 1'b1; d = 4'd1;
      step();
      load = 1'b0; up = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({q_s, tc_s} !== {4'd0, 1'(i == 1)}) begin
            errors++;
            $display("FAIL sat_down step %0d: q/tc=%0d/%0b expected 0/%0b", i, q_s, tc_s, i == 1);
         end
         checks++;
         if ({q_w, tc_w} !== {((i == 1) ? 4'd15 : 4'd0), 1'(i == 1)}) begin
            errors++;
            $display("FAIL wrap_down15 step %0d: q/tc=%0d/%0b expected %0d/%0b",
                     i, q_w, tc_w, (i == 1) ? 15 : 0, i == 1);
         end
      end
   endtask

   task automatic test_load_priority();
      idle();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0; limit = 4'd9; load = 1'b1; d = 4'd12;
      step();
      checks++;
      if ({q_w, tc_w, ovf_w, q_s, tc_s, ovf_s} !== {4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load_clamp: wrap %0d/%0b/%0b sat %0d/%0b/%0b expected 9/0/0 both",
                  q_w, tc_w, ovf_w, q_s, tc_s, ovf_s);
      end
      en = 1'b1; up = 1'b1; d = 4'd5;
      step();
      checks++;
      if ({q_w, tc_w, q_s, tc_s} !== {4'd5, 1'b0, 4'd5, 1'b0}) begin
         errors++;
         $display("FAIL load_over_en: wrap q/tc=%0d/%0b sat q/tc=%0d/%0b expected 5/0 both",
                  q_w, tc_w, q_s, tc_s);
      end
      load = 1'b0; limit = 4'd5; clr_ovf = 1'b1;
      step();
      checks++;
      if ({q_w, tc_w, ovf_w, q_s, tc_s, ovf_s} !== {4'd0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL set_beats_clr: wrap %0d/%0b/%0b sat %0d/%0b/%0b expected 0/1/1 and 5/1/1",
                  q_w, tc_w, ovf_w, q_s, tc_s, ovf_s);
      end
   endtask

   task automatic test_limit_change();
      idle();
      limit = 4'd9; load = 1'b1; d = 4'd7;
      step();
      load = 1'b0; limit = 4'd4; en = 1'b1; up = 1'b1;
      step();
      checks++;
      if ({q_w, tc_w, q_s, tc_s} !== {4'd0, 1'b1, 4'd4, 1'b1}) begin
         errors++;
         $display("FAIL limit_drop_up: wrap q/tc=%0d/%0b sat q/tc=%0d/%0b expected 0/1 and 4/1",
                  q_w, tc_w, q_s, tc_s);
      end
      idle();
      limit = 4'd9; load = 1'b1; d = 4'd7;
      step();
      load = 1'b0; limit = 4'd4; en = 1'b1; up = 1'b0;
      step();
      checks++;
      if ({q_w, tc_w, q_s, tc_s} !== {4'd6, 1'b0, 4'd6, 1'b0}) begin
         errors++;
         $display("FAIL limit_drop_down: wrap q/tc=%0d/%0b sat q/tc=%0d/%0b expected 6/0 both",
                  q_w, tc_w, q_s, tc_s);
      end
      idle();
      limit = 4'd0; load = 1'b1; d = 4'd0;
      step();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         up = (i < 2);
         step();
         checks++;
         if ({q_w, tc_w, ovf_w, q_s, tc_s, ovf_s} !== {4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL limit0 step %0d: wrap %0d/%0b/%0b sat %0d/%0b/%0b expected 0/1/1 both",
                     i, q_w, tc_w, ovf_w, q_s, tc_s, ovf_s);
         end
      end
   endtask

   task automatic test_reset_mid_count();
      idle();
      limit = 4'd9; load = 1'b1; d = 4'd3;
      step();
      load = 1'b0; en = 1'b1; up = 1'b1;
      step();
      rst = 1'b1; load = 1'b1; d = 4'd7;
      step();
      checks++;
      if ({q_w, tc_w, ovf_w, q_s, tc_s, ovf_s} !== 12'd0) begin
         errors++;
         $display("FAIL reset_mid: wrap %0d/%0b/%0b sat %0d/%0b/%0b expected 0/0/0 both",
                  q_w, tc_w, ovf_w, q_s, tc_s, ovf_s);
      end
      rst = 1'b0; load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if ({q_w, tc_w, q_s, tc_s} !== {4'(i), 1'b0, 4'(i), 1'b0}) begin
            errors++;
            $display("FAIL resume step %0d: wrap q/tc=%0d/%0b sat q/tc=%0d/%0b expected %0d/0 both",
                     i, q_w, tc_w, q_s, tc_s, i);
         end
      end
   endtask

   initial begin
      idle();
      limit = 4'd9;
      test_reset();
      test_count_up();
      test_count_down_clr();
      test_saturate();
      test_load_priority();
      test_limit_change();
      test_reset_mid_count();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
